// File: rtl/data_mem_sized.sv
// data_mem_sized
// ---------------------------------------------------------------------------
// Byte-addressed, little-endian data RAM for the MEM stage of a MIPS-style
// pipeline. Supports lb/lbu/lh/lhu/lw/sb/sh/sw through a valid/ready request
// port and a one-cycle response pulse. Each request takes LATENCY+2 cycles
// from accept to the next accept. Misaligned, reserved-size and
// out-of-range accesses are rejected with resp_error and never touch the RAM.
//
// Parameters
//   DEPTH       number of 32-bit words (power of two, >= 4)
//   LATENCY     extra wait cycles between accept and response (0..15)
//   ADDR_WIDTH  width of the byte address
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous, active-high; drops any pending request
//   req_valid     request present
//   req_ready     block is idle and will accept a request this cycle
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 reserved (always an error)
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   req_address   byte address
//   req_wdata     store data, right-aligned
//   resp_valid    one-cycle response pulse
//   resp_rdata    load result (0 for stores, errors and when idle)
//   resp_error    access rejected (meaningful only with resp_valid)
// ---------------------------------------------------------------------------
module data_mem_sized #(
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 1,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Captured request
  logic                  wr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  // Response bookkeeping, loaded on the commit edge
  logic       resp_err_q;
  logic       resp_load_q;
  logic [1:0] resp_lane_q;
  logic [1:0] resp_size_q;
  logic       resp_uns_q;

  logic accept;
  logic commit;

  assign accept = req_valid && (state_q == IDLE);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      wr_q    <= req_write;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_address;
      wdata_q <= req_wdata;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);

  // ---------------------------------------------------------------------
  // Commit: the edge that enters RESP. With LATENCY = 0 that is the accept
  // edge itself, so the request must come straight from the input port
  // rather than from the capture registers.
  // ---------------------------------------------------------------------
  logic                  eff_wr;
  logic [1:0]            eff_size;
  logic                  eff_uns;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [31:0]           eff_wdata;

  always_comb begin
    if (state_q == IDLE) begin
      eff_wr    = req_write;
      eff_size  = req_size;
      eff_uns   = req_unsigned;
      eff_addr  = req_address;
      eff_wdata = req_wdata;
    end else begin
      eff_wr    = wr_q;
      eff_size  = size_q;
      eff_uns   = uns_q;
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
    end
  end

  // A reset on the commit edge wins, so it also suppresses the write.
  assign commit = (state_d == RESP) && (state_q != RESP) && !reset;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             out_of_range;
  logic             misaligned;
  logic             acc_err;

  assign idx  = eff_addr[IDX_W+1:2];
  assign lane = eff_addr[1:0];

  generate
    if (ADDR_WIDTH > IDX_W + 2) begin : g_range
      assign out_of_range = |eff_addr[ADDR_WIDTH-1:IDX_W+2];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  always_comb begin
    misaligned = 1'b0;
    case (eff_size)
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign acc_err = (eff_size == 2'b11) || misaligned || out_of_range;

  // ---------------------------------------------------------------------
  // Store merge: replicate the right-aligned data across the lanes and
  // let the byte enables pick which lanes actually change.
  // ---------------------------------------------------------------------
  logic [3:0]  byte_en;
  logic [31:0] wdata_lanes;
  logic        we;

  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = eff_wdata;
    case (eff_size)
      2'b00: begin
        byte_en     = 4'b0001 << lane;
        wdata_lanes = {4{eff_wdata[7:0]}};
      end
      2'b01: begin
        byte_en     = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{eff_wdata[15:0]}};
      end
      2'b10: begin
        byte_en     = 4'b1111;
        wdata_lanes = eff_wdata;
      end
      default: begin
        byte_en     = 4'b0000;
        wdata_lanes = eff_wdata;
      end
    endcase
  end

  assign we = commit && eff_wr && !acc_err;

  // ---------------------------------------------------------------------
  // RAM: one byte-wide array per lane so each lane has its own write
  // enable; every lane registers its read on the commit edge.
  // ---------------------------------------------------------------------
  logic [31:0] rd_word;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clock) begin
        if (we && byte_en[gi]) begin
          mem[idx] <= wdata_lanes[gi*8 +: 8];
        end
        if (commit) begin
          rd_q <= mem[idx];
        end
      end

      assign rd_word[gi*8 +: 8] = rd_q;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_err_q  <= 1'b0;
      resp_load_q <= 1'b0;
      resp_lane_q <= 2'b00;
      resp_size_q <= 2'b00;
      resp_uns_q  <= 1'b0;
    end else if (commit) begin
      resp_err_q  <= acc_err;
      resp_load_q <= !eff_wr && !acc_err;
      resp_lane_q <= lane;
      resp_size_q <= eff_size;
      resp_uns_q  <= eff_uns;
    end
  end

  // ---------------------------------------------------------------------
  // Load extract
  // ---------------------------------------------------------------------
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_val;

  always_comb begin
    case (resp_lane_q)
      2'b00:   sel_byte = rd_word[7:0];
      2'b01:   sel_byte = rd_word[15:8];
      2'b10:   sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    sel_half = resp_lane_q[1] ? rd_word[31:16] : rd_word[15:0];

    case (resp_size_q)
      2'b00:   load_val = {{24{~resp_uns_q & sel_byte[7]}}, sel_byte};
      2'b01:   load_val = {{16{~resp_uns_q & sel_half[15]}}, sel_half};
      default: load_val = rd_word;
    endcase
  end

  assign resp_rdata = (resp_valid && resp_load_q) ? load_val : 32'h0;
  assign resp_error = resp_valid && resp_err_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// Bench for data_mem_sized: three instances (LATENCY 2, 3, 0, DEPTH 256)
// driven with directed vectors. A byte-array model with cycle-time
// bookkeeping predicts ready/valid/error/rdata for every cycle.
module tb_data_mem_sized;

  localparam int N = 3;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 3 : 0;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [N];
  logic        valid  [N];
  logic        write  [N];
  logic [1:0]  size   [N];
  logic        uns    [N];
  logic [31:0] addr   [N];
  logic [31:0] wdata  [N];
  logic        ready  [N];
  logic        rv     [N];
  logic [31:0] rdata  [N];
  logic        rerr   [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 3 : 0;
    data_mem_sized #(.DEPTH(256), .LATENCY(LAT), .ADDR_WIDTH(32)) u_dut (
      .clock       (clk),
      .reset       (rst[gi]),
      .req_valid   (valid[gi]),
      .req_ready   (ready[gi]),
      .req_write   (write[gi]),
      .req_size    (size[gi]),
      .req_unsigned(uns[gi]),
      .req_address (addr[gi]),
      .req_wdata   (wdata[gi]),
      .resp_valid  (rv[gi]),
      .resp_rdata  (rdata[gi]),
      .resp_error  (rerr[gi])
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Model: memory as bytes, timing as edge numbers.
  // ---------------------------------------------------------------------
  logic [7:0]  mm [N][1024];
  bit          mk [N][1024];
  bit          busy [N];
  int          commit_at [N];
  int          done_at [N];
  bit          exp_v [N];
  bit          exp_e [N];
  logic [31:0] exp_d [N];
  bit          exp_known [N];
  bit          p_wr [N];
  logic [1:0]  p_size [N];
  bit          p_uns [N];
  logic [31:0] p_addr [N];
  logic [31:0] p_wdata [N];
  int          model_resps [N];
  int          dut_resps [N];
  int          cyc = 0;
  bit          chk_en = 0;

  task automatic model_commit(input int i);
    int n;
    logic [31:0] a, v;
    bit known;
    a = p_addr[i];
    n = 1 << p_size[i];
    exp_e[i] = (p_size[i] == 2'b11) || (a >= 32'd1024) || (a % n != 0);
    exp_d[i] = 32'h0;
    exp_known[i] = 1;
    if (!exp_e[i]) begin
      if (p_wr[i]) begin
        for (int k = 0; k < n; k++) begin
          mm[i][a+k] = p_wdata[i][8*k +: 8];
          mk[i][a+k] = 1;
        end
      end else begin
        v = 0;
        known = 1;
        for (int k = 0; k < n; k++) begin
          v = v | (32'(mm[i][a+k]) << (8*k));
          known = known & mk[i][a+k];
        end
        if (!p_uns[i] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        exp_d[i] = v;
        exp_known[i] = known;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      busy[i] = 0; exp_v[i] = 0; model_resps[i] = 0; dut_resps[i] = 0;
      for (int j = 0; j < 1024; j++) mk[i][j] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        bit was_ready;
        was_ready = !busy[i];
        exp_v[i] = 0;
        if (rst[i]) begin
          busy[i] = 0;
        end else begin
          if (busy[i] && cyc == done_at[i]) busy[i] = 0;
          if (was_ready && valid[i]) begin
            busy[i] = 1;
            p_wr[i] = write[i]; p_size[i] = size[i]; p_uns[i] = uns[i];
            p_addr[i] = addr[i]; p_wdata[i] = wdata[i];
            commit_at[i] = cyc + lat_of(i);
            done_at[i] = commit_at[i] + 1;
          end
          if (busy[i] && cyc == commit_at[i]) begin
            model_commit(i);
            exp_v[i] = 1;
            model_resps[i]++;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < N; i++) begin
          chk($sformatf("u%0d c%0d ready", i, cyc), 32'(ready[i]), 32'(!busy[i]));
          chk($sformatf("u%0d c%0d resp_valid", i, cyc), 32'(rv[i]), 32'(exp_v[i]));
          if (exp_v[i]) begin
            chk($sformatf("u%0d c%0d resp_error", i, cyc), 32'(rerr[i]), 32'(exp_e[i]));
            if (exp_known[i])
              chk($sformatf("u%0d c%0d resp_rdata", i, cyc), rdata[i], exp_d[i]);
          end else begin
            chk($sformatf("u%0d c%0d idle rdata", i, cyc), rdata[i], 32'h0);
          end
          if (rv[i] === 1'b1) dut_resps[i]++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------
  task automatic send(input int i, input bit w, input logic [1:0] sz, input bit u,
                      input logic [31:0] a, input logic [31:0] d);
    int t;
    write[i] = w; size[i] = sz; uns[i] = u; addr[i] = a; wdata[i] = d;
    valid[i] = 1;
    t = 0;
    while (ready[i] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      total++; bad++;
      $display("FAIL u%0d accept timeout actual=not-ready required=ready", i);
    end
    @(posedge clk);
    #1 valid[i] = 0;
  endtask

  task automatic wait_resp(input int i, input string nm, input logic [31:0] lit_d,
                           input bit lit_e, input bit chk_d);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (rv[i] !== 1'b1 && t < 50);
    if (rv[i] !== 1'b1) begin
      total++; bad++;
      $display("FAIL %s response timeout actual=none required=resp_valid", nm);
    end else begin
      chk({nm, " err"}, 32'(rerr[i]), 32'(lit_e));
      chk({nm, " model err"}, 32'(exp_e[i]), 32'(lit_e));
      if (chk_d) begin
        chk({nm, " data"}, rdata[i], lit_d);
        chk({nm, " model data"}, exp_d[i], lit_d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int i, input string nm, input bit w, input logic [1:0] sz,
                    input bit u, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] lit_d, input bit lit_e);
    send(i, w, sz, u, a, d);
    wait_resp(i, nm, lit_d, lit_e, 1'b1);
    $display("u%0d %s addr=%h -> rdata=%h err=%0d", i, nm, a, lit_d, lit_e);
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    for (int i = 0; i < N; i++) begin
      rst[i] = 1; valid[i] = 0; write[i] = 0; size[i] = 0; uns[i] = 0;
      addr[i] = 0; wdata[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    for (int i = 0; i < N; i++) rst[i] = 0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d reset ready", i), 32'(ready[i]), 32'd1);
      chk($sformatf("u%0d reset valid", i), 32'(rv[i]), 32'd0);
      chk($sformatf("u%0d reset rdata", i), rdata[i], 32'h0);
      chk($sformatf("u%0d reset error", i), 32'(rerr[i]), 32'd0);
    end
    @(posedge clk);
    #1;

    // LATENCY=2: sw with explicit ready/valid timing
    send(0, 1, 2'b10, 0, 32'h10, 32'h1122_3344);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("sw timing ready k%0d", k), 32'(ready[0]), 32'd0);
      chk($sformatf("sw timing valid k%0d", k), 32'(rv[0]), (k == 2) ? 32'd1 : 32'd0);
      if (k == 2) begin
        chk("sw timing err", 32'(rerr[0]), 32'd0);
        chk("sw timing rdata", rdata[0], 32'h0);
      end
    end
    @(negedge clk);
    chk("sw timing ready after", 32'(ready[0]), 32'd1);
    chk("sw timing valid after", 32'(rv[0]), 32'd0);
    @(posedge clk);
    #1;
    $display("u0 sw addr=00000010 data=11223344 timing checked");

    op(0, "lw",  0, 2'b10, 0, 32'h10, 0, 32'h1122_3344, 0);
    op(0, "sb",  1, 2'b00, 0, 32'h11, 32'h0000_00AA, 32'h0, 0);
    op(0, "lw",  0, 2'b10, 0, 32'h10, 0, 32'h1122_AA44, 0);
    op(0, "lb",  0, 2'b00, 0, 32'h11, 0, 32'hFFFF_FFAA, 0);
    op(0, "lbu", 0, 2'b00, 1, 32'h11, 0, 32'h0000_00AA, 0);
    op(0, "sh",  1, 2'b01, 0, 32'h12, 32'h0000_8001, 32'h0, 0);
    op(0, "lw",  0, 2'b10, 0, 32'h10, 0, 32'h8001_AA44, 0);
    op(0, "lh",  0, 2'b01, 0, 32'h12, 0, 32'hFFFF_8001, 0);
    op(0, "lhu", 0, 2'b01, 1, 32'h12, 0, 32'h0000_8001, 0);
    op(0, "lw misaligned", 0, 2'b10, 0, 32'h13, 0, 32'h0, 1);
    op(0, "sh misaligned", 1, 2'b01, 0, 32'h11, 32'h0000_FFFF, 32'h0, 1);
    op(0, "size11", 0, 2'b11, 0, 32'h10, 0, 32'h0, 1);
    op(0, "lw after errors", 0, 2'b10, 0, 32'h10, 0, 32'h8001_AA44, 0);
    op(0, "sw out of range", 1, 2'b10, 0, 32'h400, 32'h1234_5678, 32'h0, 1);
    op(0, "sw top", 1, 2'b10, 0, 32'h3FC, 32'hA5A5_5A5A, 32'h0, 0);

    // lw @0x3FC while toggling a store request during WAIT and RESP
    send(0, 0, 2'b10, 0, 32'h3FC, 0);
    write[0] = 1; size[0] = 2'b10; addr[0] = 32'h10; wdata[0] = 32'hFFFF_FFFF;
    valid[0] = 1;
    @(posedge clk);
    #1 valid[0] = 0;
    @(posedge clk);
    #1 valid[0] = 1;
    wait_resp(0, "lw top toggled", 32'hA5A5_5A5A, 0, 1'b1);
    valid[0] = 0;
    $display("u0 lw addr=000003fc with toggled req_valid -> rdata=a5a55a5a err=0");
    op(0, "lw after toggle", 0, 2'b10, 0, 32'h10, 0, 32'h8001_AA44, 0);

    // LATENCY=3: reset during WAIT, then reset on the commit edge
    op(1, "sw seed", 1, 2'b10, 0, 32'h20, 32'h0102_0304, 32'h0, 0);
    send(1, 1, 2'b10, 0, 32'h20, 32'hDEAD_BEEF);
    @(posedge clk);
    #1 rst[1] = 1;
    @(posedge clk);
    #1 rst[1] = 0;
    @(negedge clk);
    chk("reset in WAIT ready", 32'(ready[1]), 32'd1);
    chk("reset in WAIT valid", 32'(rv[1]), 32'd0);
    @(posedge clk);
    #1;
    $display("u1 sw addr=00000020 data=deadbeef dropped by reset");
    op(1, "lw after reset", 0, 2'b10, 0, 32'h20, 0, 32'h0102_0304, 0);
    send(1, 1, 2'b10, 0, 32'h20, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst[1] = 1;
    @(posedge clk);
    #1 rst[1] = 0;
    $display("u1 sw addr=00000020 data=cafef00d reset on commit edge");
    op(1, "lw after commit reset", 0, 2'b10, 0, 32'h20, 0, 32'h0102_0304, 0);

    // LATENCY=0
    op(2, "sw L0", 1, 2'b10, 0, 32'h40, 32'h5566_7788, 32'h0, 0);
    op(2, "lw L0", 0, 2'b10, 0, 32'h40, 0, 32'h5566_7788, 0);
    op(2, "lhu L0", 0, 2'b01, 1, 32'h42, 0, 32'h0000_5566, 0);
    op(2, "lb L0 hi", 0, 2'b00, 0, 32'h43, 0, 32'h0000_0055, 0);
    op(2, "lb L0 lo", 0, 2'b00, 0, 32'h40, 0, 32'hFFFF_FF88, 0);
    write[2] = 0; size[2] = 2'b10; uns[2] = 0; addr[2] = 32'h40;
    valid[2] = 1;
    repeat (4) @(posedge clk);
    #1 valid[2] = 0;
    repeat (2) @(posedge clk);
    #1;
    $display("u2 back-to-back lw addr=00000040 x2");
    op(2, "sw L0 oor", 1, 2'b00, 0, 32'h0000_1000, 32'h11, 32'h0, 1);

    for (int i = 0; i < N; i++)
      chk($sformatf("u%0d response count", i), 32'(dut_resps[i]), 32'(model_resps[i]));
    chk("u2 response count literal", 32'(dut_resps[2]), 32'd8);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
